// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select codes and scoreboard state shared by the hazard unit
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  typedef enum logic {IDLE, BUSY} sb_state_t;
endpackage

// File: rtl/mdu_scoreboard.sv
// mdu_scoreboard: tracks one in-flight multi-cycle MDU op, its destination and protocol errors
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int MDU_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] dst_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] dst,
  output logic [3:0]    cnt
);
  sb_state_t state;
  // accept a start when idle, count down while busy, flag starts that arrive while busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dst   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= BUSY;
          cnt   <= 4'(MDU_LAT);
          dst   <= dst_in;
          busy  <= 1'b1;
        end
        BUSY: begin
          cnt  <= cnt - 4'd1;
          done <= cnt == 4'd2;
          err  <= err | start;
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects, pipeline stalls and MDU scoreboard for a 5-stage pipeline
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra_d,
  input  logic [AW-1:0]    rb_d,
  input  logic [AW-1:0]    wr_reg_d,
  input  logic             reg_write_d,
  input  logic             mdu_op_d,
  input  logic [AW-1:0]    ra_e,
  input  logic [AW-1:0]    rb_e,
  input  logic [AW-1:0]    wr_reg_e,
  input  logic             reg_write_e,
  input  logic             mem_to_reg_e,
  input  logic             mdu_start_e,
  input  logic [AW-1:0]    wr_reg_m,
  input  logic [AW-1:0]    wr_reg_w,
  input  logic             reg_write_m,
  input  logic             mem_to_reg_m,
  input  logic             reg_write_w,
  input  logic             branch_d,
  input  logic             clr_cnt,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic             mdu_err,
  output logic [AW-1:0]    mdu_dst,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [3:0] cnt;
  logic wm, ww, we, lw_stall, br_stall, raw_stall, struct_stall, stall;
  assign wm = reg_write_m && wr_reg_m != '0;
  assign ww = reg_write_w && wr_reg_w != '0;
  assign we = wr_reg_e != '0;
  assign fwd_a_e = (wm && wr_reg_m == ra_e) ? FWD_M : (ww && wr_reg_w == ra_e) ? FWD_W : FWD_RF;
  assign fwd_b_e = (wm && wr_reg_m == rb_e) ? FWD_M : (ww && wr_reg_w == rb_e) ? FWD_W : FWD_RF;
  assign fwd_a_d = wm && wr_reg_m == ra_d;
  assign fwd_b_d = wm && wr_reg_m == rb_d;
  assign lw_stall = mem_to_reg_e && we && (wr_reg_e == ra_d || wr_reg_e == rb_d);
  assign br_stall = branch_d &&
    ((reg_write_e && we && (wr_reg_e == ra_d || wr_reg_e == rb_d)) ||
     (mem_to_reg_m && wr_reg_m != '0 && (wr_reg_m == ra_d || wr_reg_m == rb_d)));
  assign raw_stall = mdu_busy && mdu_dst != '0 &&
    (ra_d == mdu_dst || rb_d == mdu_dst || (reg_write_d && wr_reg_d == mdu_dst));
  assign struct_stall = mdu_busy && mdu_op_d && cnt != 4'd1;
  assign stall   = lw_stall || br_stall || raw_stall || struct_stall;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  mdu_scoreboard #(.AW(AW), .MDU_LAT(MDU_LAT)) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mdu_start_e),
    .dst_in (wr_reg_e),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .err    (mdu_err),
    .dst    (mdu_dst),
    .cnt    (cnt)
  );
  // saturating count of stalled cycles; clear wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else stall_cnt <= clr_cnt ? '0 : (stall && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter AW, default 5, register-address width (2**AW architectural registers).
REQ-002 Parameter MDU_LAT, default 4, multi-cycle multiply/divide latency in cycles; legal range 2..15.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 ra_d, rb_d  in  AW  D-stage source registers; wr_reg_d in AW, reg_write_d in 1, mdu_op_d in 1 describe the D-stage instruction.
REQ-007 ra_e, rb_e, wr_reg_e  in  AW  E-stage sources and destination; reg_write_e, mem_to_reg_e, mdu_start_e  in  1.
REQ-008 wr_reg_m, wr_reg_w  in  AW; reg_write_m, mem_to_reg_m, reg_write_w  in  1  M/W-stage write info.
REQ-009 branch_d  in  1  D-stage branch compare; clr_cnt  in  1  synchronous stall-counter clear.
REQ-010 stall_f, stall_d, flush_e  out  1  pipeline controls.
REQ-011 fwd_a_e, fwd_b_e  out  2  E operand select: 00 regfile, 01 W, 10 M; fwd_a_d, fwd_b_d  out  1  D branch-operand forward from M.
REQ-012 mdu_busy, mdu_done, mdu_err  out  1; mdu_dst  out  AW; stall_cnt  out  CNT_W.

Function
REQ-013 Forwarding: fwd_x_e = 10 if reg_write_m, wr_reg_m!=0 and wr_reg_m==r_x_e; else 01 if same with W; else 00; M has priority.
REQ-014 fwd_x_d = reg_write_m && wr_reg_m!=0 && wr_reg_m==r_x_d.
REQ-015 lw_stall = mem_to_reg_e && wr_reg_e!=0 && (wr_reg_e==ra_d || wr_reg_e==rb_d).
REQ-016 br_stall = branch_d && ((reg_write_e && wr_reg_e!=0 && wr_reg_e matches ra_d/rb_d) || (mem_to_reg_m && wr_reg_m!=0 && wr_reg_m matches ra_d/rb_d)).
REQ-017 Scoreboard: state IDLE/BUSY, a down-counter cnt (4 bits) and a destination register mdu_dst.
REQ-018 IDLE: mdu_start_e=1 loads cnt=MDU_LAT, mdu_dst=wr_reg_e, enters BUSY next cycle.
REQ-019 BUSY: cnt decrements each cycle; mdu_done=1 in the cycle where cnt==1; the next cycle returns to IDLE; a start is therefore accepted at t, mdu_busy=1 for cycles t+1..t+MDU_LAT.
REQ-020 mdu_raw_stall = mdu_busy && mdu_dst!=0 && (ra_d, rb_d or (reg_write_d && wr_reg_d)) equals mdu_dst; this covers RAW and WAW.
REQ-021 mdu_struct_stall = mdu_busy && mdu_op_d && cnt!=1; an MDU op in D is released on the mdu_done cycle.
REQ-022 mdu_start_e while BUSY is a protocol violation: it is ignored and sets sticky mdu_err (cleared only by reset).
REQ-023 mdu_start_e in the mdu_done cycle counts as a violation (REQ-021 prevents it legally).
REQ-024 stall = lw_stall || br_stall || mdu_raw_stall || mdu_struct_stall; stall_f = stall_d = flush_e = stall, combinational.
REQ-025 stall_cnt increments by 1 each cycle stall_d=1 and saturates at 2**CNT_W-1; clr_cnt has priority over the increment (the counter reads 0 next cycle).
REQ-026 Forwarding and stall outputs are combinational with zero latency; scoreboard outputs are registered.

Reset
REQ-027 Async assert, while rst_n=0: state=IDLE, cnt=0, mdu_dst=0, mdu_busy=0, mdu_done=0, mdu_err=0, stall_cnt=0.
REQ-028 Reset mid-operation abandons the MDU op with no mdu_done; the first edge after release samples normally.

Structure
REQ-029 Shared package hazard_pkg holds the forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10 and the scoreboard state enum.
REQ-030 One sub-module, mdu_scoreboard, holds the state, cnt, mdu_dst and mdu_err; forwarding/stall logic and the counter stay in the top.

Verification
REQ-031 Check forwarding priority: with wr_reg_m=wr_reg_w=3, reg_write_m=reg_write_w=1 and ra_e=3, fwd_a_e=10; with reg_write_m=0, fwd_a_e=01; with both writing r0 and ra_e=0, fwd_a_e=00.
REQ-032 Check load-use: mem_to_reg_e=1, wr_reg_e=8, rb_d=8 gives stall_f/stall_d/flush_e=1 for 1 cycle; stall_cnt +1.
REQ-033 Check MDU latency: mdu_start_e with wr_reg_e=9 at t and MDU_LAT=4 gives busy t+1..t+4, mdu_done only at t+4; ra_d=9 stalls t+1..t+4.
REQ-034 Check the structural stall: mdu_op_d=1 during BUSY stalls until the mdu_done cycle, then releases; a forced mdu_start_e in BUSY sets mdu_err and leaves cnt unchanged.
REQ-035 Check the counter and reset: with CNT_W=2, continuous stall holds stall_cnt at 3; clr_cnt together with a stall gives 0; rst_n low at t+2 of an MDU op clears busy immediately with no mdu_done.
